shift_arbiter_ctrl: RTL and testbench
=====================================

Name: shift_arbiter_ctrl

Overview:
- Shares one serial arithmetic-right-shift engine between two requesters.
- Arbitrates round-robin and sequences the shift one bit per clock.
- Returns the sign-filled result with a valid/ready response handshake.
- Sits between ALU operand sources and the ALU result path, in the same logical/arithmetic operand group as the combinational shifters.

Parameters:
N, 4, data width and shift-amount width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 accepted this cycle.
req0_data  input  N  requester 0 operand.
req0_amount  input  N  requester 0 shift amount, unsigned.
req1_valid  input  1  requester 1 has an operation.
req1_ready  output  1  requester 1 accepted this cycle.
req1_data  input  N  requester 1 operand.
req1_amount  input  N  requester 1 shift amount, unsigned.
resp_valid  output  1  result available.
resp_ready  input  1  consumer takes the result.
resp_data  output  N  arithmetic-right-shifted result.
resp_id  output  1  index of the requester that owns the result.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - resp_valid, resp_data, resp_id, busy = 0.
  - Count = 0.
  - Round-robin pointer = requester 0.
- Reset asserted mid-operation aborts the operation. No result is produced and the pointer returns to requester 0.
- States:
  - IDLE: waits for a request.
  - SHIFT: one-bit arithmetic right shift per edge, MSB replicated; count decrements each edge.
  - DONE: holds resp_valid.
- Grant (combinational, IDLE only):
  - Only one valid: that requester wins.
  - Both valid: the requester indicated by the pointer wins.
  - reqX_ready = IDLE and reqX_valid and X is the grant. At most one ready per cycle.
  - Both ready outputs are 0 outside IDLE.
- Accept edge (valid and ready):
  - Load the operand register and resp_id.
  - Effective count k = min(amount, N).
  - Pointer set to the other requester.
  - k = 0: go to DONE. k > 0: go to SHIFT.
- SHIFT: on each edge, operand = {operand[N-1], operand[N-1:1]} and count decrements. The edge that shifts with count = 1 moves to DONE.
- Latency: resp_valid first high in the cycle after edge E0+k, where E0 is the accept edge.
  - Total busy cycles = k+1.
- Saturation: amount >= N gives all bits equal to the original operand MSB after N shifts.
- DONE:
  - resp_valid = 1.
  - resp_data and resp_id stable while resp_ready = 0 (unbounded backpressure).
  - The edge with resp_ready = 1 returns to IDLE and clears resp_valid.
  - A new accept is possible on the following cycle at the earliest, so there is no accept in the same cycle as the response handshake.
- resp_data holds the last result after the handshake but is only meaningful while resp_valid = 1.
- Requester inputs are sampled only at the accept edge; later changes are ignored.
- A requester's valid dropping while not granted is legal, with no state effect.

Decomposition:
- Package shift_ctrl_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - localparam REQ0 = 1'b0, REQ1 = 1'b1.
  - A function computing the saturating count min(amount, N).
- Sub-module sra_step (parameter N): combinational one-bit arithmetic right shift, instantiated once on the operand register.
- Arbiter, counter and FSM stay in the top module.

Test Plan:
1. Single op, N = 4. req0 data 4'b1000, amount 2 -> resp_valid after 2 edges past accept, resp_data 4'b1110, resp_id 0, busy high for 3 cycles.
2. Zero shift. req1 data 4'b0110, amount 0 -> resp_valid the cycle after accept, resp_data 4'b0110, resp_id 1.
3. Saturation. req0 data 4'b1010, amount 4'b1111 -> resp_data 4'b1111 after exactly 4 SHIFT cycles. Data 4'b0101, amount 9 -> 4'b0000.
4. Fairness. From reset, both requesters hold valid with amount 1, resp_ready = 1 -> grants in order 0, 1, 0, 1. Never both ready in the same cycle.
5. Backpressure. Hold resp_ready = 0 for 3 cycles in DONE -> resp_valid, resp_data and resp_id constant, both ready outputs 0. Release -> IDLE on the next edge, next accept one cycle later.
6. Reset mid-SHIFT. Assert rst_n = 0 during a 3-bit shift -> all outputs 0 immediately, with no edge required. After release, simultaneous requests grant requester 0.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the round-robin serial arithmetic-shift controller.
// Holds the FSM state encoding, the requester ids and the saturating shift count.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Shifting an N-bit word more than N times changes nothing, so clamp to N.
  function automatic int sat_count(input int amount, input int n);
    return (amount > n) ? n : amount;
  endfunction

endpackage

// File: rtl/shift_arbiter_ctrl_sra_step.sv
// One-bit arithmetic right shift with sign replication.
// Purely combinational, zero latency; no flow control.
module sra_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  assign dout = {din[N-1], din[N-1:1]};

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Two-requester round-robin front end for one serial arithmetic-right-shift engine.
// Result arrives min(amount,N)+1 cycles after accept; the result is held in DONE until resp_ready.
module shift_arbiter_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_data,
  input  logic [N-1:0] req0_amount,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_data,
  input  logic [N-1:0] req1_amount,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_data,
  output logic         resp_id,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] operand;
  logic [N-1:0] shifted;
  logic [CW-1:0] count;
  logic         ptr;
  logic         id_q;
  logic         grant_id;
  logic         accept;
  logic [N-1:0] sel_data;
  logic [N-1:0] sel_amount;
  logic [CW-1:0] k;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_id = REQ0;
    if (req0_valid && req1_valid) begin
      grant_id = ptr;
    end else if (req1_valid) begin
      grant_id = REQ1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && (grant_id == REQ0);
  assign req1_ready = (state == IDLE) && req1_valid && (grant_id == REQ1);
  assign accept     = req0_ready || req1_ready;

  assign sel_data   = (grant_id == REQ1) ? req1_data   : req0_data;
  assign sel_amount = (grant_id == REQ1) ? req1_amount : req0_amount;
  assign k          = CW'(sat_count(int'(sel_amount), N));

  sra_step #(.N(N)) u_sra_step (
    .din  (operand),
    .dout (shifted)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (k == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (count == CW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      operand <= '0;
      count   <= '0;
      ptr     <= REQ0;
      id_q    <= REQ0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        operand <= sel_data;
        id_q    <= grant_id;
        count   <= k;
        ptr     <= ~grant_id;
      end else if (state == SHIFT) begin
        operand <= shifted;
        count   <= count - CW'(1);
      end
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_data  = operand;
  assign resp_id    = id_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Self-checking bench for shift_arbiter_ctrl (N = 4): directed scenarios plus random
// operations scored against an integer-arithmetic reference and a round-robin pointer model.
module tb_shift_arbiter_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_data;
  logic [N-1:0] req0_amount;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_data;
  logic [N-1:0] req1_amount;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_data;
  logic         resp_id;
  logic         busy;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic mptr     = 1'b0;

  shift_arbiter_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data   (req0_data),
    .req0_amount (req0_amount),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data   (req1_data),
    .req1_amount (req1_amount),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_id     (resp_id),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ref_k(input logic [3:0] a);
    return (int'(a) > N) ? N : int'(a);
  endfunction

  // Signed value floor-divided by 2^k, truncated back to N bits.
  function automatic logic [3:0] ref_sra(input logic [3:0] d, input logic [3:0] a);
    int v;
    v = d[3] ? int'(d) - 16 : int'(d);
    v = v >>> ref_k(a);
    return v[3:0];
  endfunction

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    rst_n = 0;
    #12;
    rst_n = 1;
    @(posedge clk); #1;
    mptr = 1'b0;
  endtask

  task automatic run_op(input logic v0, input logic v1,
                        input logic [3:0] d0, input logic [3:0] a0,
                        input logic [3:0] d1, input logic [3:0] a1,
                        output logic to, output logic gid, output logic [3:0] gdata,
                        output logic rid, output int lat, output int bcnt);
    int w;
    to = 0; gid = 0; gdata = 0; rid = 0; lat = 0; bcnt = 0; w = 0;
    req0_valid = v0; req0_data = d0; req0_amount = a0;
    req1_valid = v1; req1_data = d1; req1_amount = a1;
    resp_ready = 1;
    #1;
    while (!req0_ready && !req1_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) begin
      to = 1; req0_valid = 0; req1_valid = 0;
      return;
    end
    gid = req1_ready;
    @(posedge clk); #1;
    // Inputs scrambled after accept must not affect the result.
    req0_valid = 0; req1_valid = 0;
    req0_data = 4'($urandom); req1_data = 4'($urandom);
    req0_amount = 4'($urandom); req1_amount = 4'($urandom);
    while (!resp_valid && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1; lat++;
    end
    if (busy) bcnt++;
    gdata = resp_data; rid = resp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_data = 0; req0_amount = 0; req1_data = 0; req1_amount = 0;
    rst_n = 0;
    #1;
    chk_cnt++;
    if ({resp_valid, resp_data, resp_id, busy, req0_ready, req1_ready} !== 9'b0)
      $display("FAIL reset_outputs: got %b required 0",
               {resp_valid, resp_data, resp_id, busy, req0_ready, req1_ready});
    else pass_cnt++;
    #11;
    rst_n = 1;
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL reset_ptr_grant: got %b required 10", {req0_ready, req1_ready});
    else pass_cnt++;
    req0_valid = 0; req1_valid = 0;
    mptr = 1'b0;
  endtask

  task automatic test_fairness();
    int n, cyc, both, w;
    logic [3:0] seq;
    apply_reset();
    n = 0; cyc = 0; both = 0; seq = 0;
    req0_valid = 1; req0_data = 4'h8; req0_amount = 1;
    req1_valid = 1; req1_data = 4'h1; req1_amount = 1;
    resp_ready = 1;
    #1;
    while (n < 4 && cyc < 100) begin
      if (req0_ready && req1_ready) both++;
      if (req0_ready || req1_ready) begin
        seq[n] = req1_ready;
        n++;
      end
      @(posedge clk); #1; cyc++;
    end
    req0_valid = 0; req1_valid = 0;
    chk_cnt++;
    if (n !== 4) $display("FAIL fair_count: got %0d grants required 4", n);
    else pass_cnt++;
    chk_cnt++;
    if (seq !== 4'b1010) $display("FAIL fair_order: got %b required 1010 (msb=4th grant)", seq);
    else pass_cnt++;
    chk_cnt++;
    if (both !== 0) $display("FAIL fair_both_ready: got %0d cycles required 0", both);
    else pass_cnt++;
    w = 0;
    while (busy && w < 20) begin @(posedge clk); #1; w++; end
    mptr = 1'b0;
  endtask

  task automatic test_single();
    logic to, gid, rid; logic [3:0] gd; int lat, bc;
    run_op(1, 0, 4'b1000, 4'd2, 4'h0, 4'h0, to, gid, gd, rid, lat, bc);
    chk_cnt++;
    if (to || gd !== 4'b1110) $display("FAIL single_data: got %b required 1110", gd);
    else pass_cnt++;
    chk_cnt++;
    if (rid !== 1'b0) $display("FAIL single_id: got %0d required 0", rid);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 2) $display("FAIL single_latency: got %0d required 2", lat);
    else pass_cnt++;
    chk_cnt++;
    if (bc !== 3) $display("FAIL single_busy: got %0d required 3", bc);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL single_idle_after: got %0d required 0", busy);
    else pass_cnt++;
    mptr = 1'b1;
  endtask

  task automatic test_zero_shift();
    logic to, gid, rid; logic [3:0] gd; int lat, bc;
    run_op(0, 1, 4'h0, 4'h0, 4'b0110, 4'd0, to, gid, gd, rid, lat, bc);
    chk_cnt++;
    if (to || gd !== 4'b0110) $display("FAIL zero_data: got %b required 0110", gd);
    else pass_cnt++;
    chk_cnt++;
    if (rid !== 1'b1) $display("FAIL zero_id: got %0d required 1", rid);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 0) $display("FAIL zero_latency: got %0d required 0", lat);
    else pass_cnt++;
    mptr = 1'b0;
  endtask

  task automatic test_saturation();
    logic to, gid, rid; logic [3:0] gd; int lat, bc;
    run_op(1, 0, 4'b1010, 4'b1111, 4'h0, 4'h0, to, gid, gd, rid, lat, bc);
    chk_cnt++;
    if (to || gd !== 4'b1111) $display("FAIL sat_neg_data: got %b required 1111", gd);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 4) $display("FAIL sat_neg_latency: got %0d required 4", lat);
    else pass_cnt++;
    run_op(1, 0, 4'b0101, 4'd9, 4'h0, 4'h0, to, gid, gd, rid, lat, bc);
    chk_cnt++;
    if (to || gd !== 4'b0000) $display("FAIL sat_pos_data: got %b required 0000", gd);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 4) $display("FAIL sat_pos_latency: got %0d required 4", lat);
    else pass_cnt++;
    mptr = 1'b1;
  endtask

  task automatic test_backpressure();
    int w;
    logic [3:0] hd; logic hid;
    req0_valid = 1; req0_data = 4'hC; req0_amount = 1;
    resp_ready = 0;
    #1;
    w = 0;
    while (!req0_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req0_valid = 0;
    w = 0;
    while (!resp_valid && w < 20) begin @(posedge clk); #1; w++; end
    hd = resp_data; hid = resp_id;
    chk_cnt++;
    if (!resp_valid || hd !== 4'hE || hid !== 1'b0)
      $display("FAIL bp_result: got v=%0d d=%h id=%0d required v=1 d=e id=0", resp_valid, hd, hid);
    else pass_cnt++;
    req1_valid = 1; req1_data = 4'h3; req1_amount = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if ({resp_valid, resp_data, resp_id, req0_ready, req1_ready} !== {1'b1, hd, hid, 2'b00})
        $display("FAIL bp_hold%0d: got %b required %b", c,
                 {resp_valid, resp_data, resp_id, req0_ready, req1_ready}, {1'b1, hd, hid, 2'b00});
      else pass_cnt++;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({resp_valid, req1_ready} !== 2'b01)
      $display("FAIL bp_release: got valid/ready1 %b required 01", {resp_valid, req1_ready});
    else pass_cnt++;
    @(posedge clk); #1;
    req1_valid = 0;
    chk_cnt++;
    if ({resp_valid, resp_data, resp_id} !== {1'b1, 4'h3, 1'b1})
      $display("FAIL bp_next_accept: got %b required 1_0011_1", {resp_valid, resp_data, resp_id});
    else pass_cnt++;
    @(posedge clk); #1;
    mptr = 1'b0;
  endtask

  task automatic test_random();
    logic to, gid, rid; logic [3:0] gd; int lat, bc;
    logic [1:0] pat; logic [3:0] d0, a0, d1, a1;
    logic ewin; logic [3:0] ed; int ek;
    for (int i = 0; i < 24; i++) begin
      pat = 2'($urandom_range(1, 3));
      d0 = 4'($urandom); a0 = 4'($urandom_range(0, 6));
      d1 = 4'($urandom); a1 = 4'($urandom_range(0, 6));
      ewin = (pat == 2'b11) ? mptr : pat[1];
      ed = ewin ? ref_sra(d1, a1) : ref_sra(d0, a0);
      ek = ewin ? ref_k(a1) : ref_k(a0);
      run_op(pat[0], pat[1], d0, a0, d1, a1, to, gid, gd, rid, lat, bc);
      chk_cnt++;
      if (to || rid !== ewin) $display("FAIL rand%0d_id: got %0d required %0d", i, rid, ewin);
      else pass_cnt++;
      chk_cnt++;
      if (gd !== ed) $display("FAIL rand%0d_data: got %h required %h", i, gd, ed);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== ek) $display("FAIL rand%0d_latency: got %0d required %0d", i, lat, ek);
      else pass_cnt++;
      mptr = ~ewin;
    end
  endtask

  task automatic test_reset_mid();
    int w;
    req0_valid = 1; req0_data = 4'b1011; req0_amount = 3;
    resp_ready = 1;
    #1;
    w = 0;
    while (!req0_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL rstmid_pre_busy: got %0d required 1", busy);
    else pass_cnt++;
    #3;
    rst_n = 0;
    #1;
    chk_cnt++;
    if ({resp_valid, resp_data, resp_id, busy, req0_ready, req1_ready} !== 9'b0)
      $display("FAIL rstmid_outputs: got %b required 0",
               {resp_valid, resp_data, resp_id, busy, req0_ready, req1_ready});
    else pass_cnt++;
    #7;
    rst_n = 1;
    mptr = 1'b0;
    req0_valid = 1; req0_data = 4'h4; req0_amount = 0;
    req1_valid = 1; req1_data = 4'h5; req1_amount = 0;
    #1;
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL rstmid_grant: got %b required 10", {req0_ready, req1_ready});
    else pass_cnt++;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk_cnt++;
    if ({resp_valid, resp_data, resp_id} !== {1'b1, 4'h4, 1'b0})
      $display("FAIL rstmid_result: got %b required 1_0100_0", {resp_valid, resp_data, resp_id});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_zero_shift();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
